// File: rtl/fg_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fg_pattern_pkg
//  Description : Shared constants and bar-colour helper for the foreground
//                test-pattern responder (RGB565 layout, pattern mode codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package fg_pattern_pkg;

    localparam int c_pix_w = 16;
    localparam int c_r_w   = 5;
    localparam int c_g_w   = 6;
    localparam int c_b_w   = 5;
    localparam int c_r_lsb = 11;
    localparam int c_g_lsb = 5;
    localparam int c_b_lsb = 0;

    localparam logic [1:0] c_mode_solid    = 2'd0;
    localparam logic [1:0] c_mode_bars     = 2'd1;
    localparam logic [1:0] c_mode_checker  = 2'd2;
    localparam logic [1:0] c_mode_gradient = 2'd3;

    localparam logic [c_pix_w-1:0] c_white = 16'hFFFF;
    localparam logic [c_pix_w-1:0] c_black = 16'h0000;

    // Bar 0 is white and bar 7 is black; each colour bit fills a whole field.
    function automatic logic [c_pix_w-1:0] bar_colour(input logic [2:0] idx);
        logic [2:0] c;
        c = 3'd7 - idx;
        return {{c_r_w{c[2]}}, {c_g_w{c[1]}}, {c_b_w{c[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fg_pattern_colour.sv
`default_nettype none
// ============================================================================
//  Module      : fg_pattern_colour
//  Description : Combinational RGB565 test-pattern generator for one pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module fg_pattern_colour
    import fg_pattern_pkg::*;
#(
    parameter int PRECISION  = 11,
    parameter int R_WIDTH    = 5,
    parameter int G_WIDTH    = 6,
    parameter int B_WIDTH    = 5,
    parameter int BAR_LOG2   = 7,
    parameter int CHECK_LOG2 = 4
) (
    input  logic [PRECISION-1:0] x,
    input  logic [PRECISION-1:0] y,
    input  logic [1:0]           mode,
    input  logic [7:0]           frame_cnt,
    input  logic [15:0]          solid_colour,
    output logic [15:0]          pixel
);

    logic [R_WIDTH-1:0] w_grad_r;
    logic [G_WIDTH-1:0] w_grad_g;
    logic [B_WIDTH-1:0] w_grad_b;
    logic               w_unused_bits;

    // Gradient red scrolls with the frame counter; sums wrap at field width.
    assign w_grad_r = R_WIDTH'(x[7:3] + frame_cnt[4:0]);
    assign w_grad_g = G_WIDTH'(y[8:3]);
    assign w_grad_b = B_WIDTH'(frame_cnt[7:3]);

    assign w_unused_bits = ^{x, y};

    always_comb begin
        pixel = c_black;
        case (mode)
            c_mode_solid:    pixel = solid_colour;
            c_mode_bars:     pixel = bar_colour(x[BAR_LOG2+2:BAR_LOG2]);
            c_mode_checker:  pixel = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? c_white : c_black;
            c_mode_gradient: begin
                pixel[c_r_lsb +: R_WIDTH] = w_grad_r;
                pixel[c_g_lsb +: G_WIDTH] = w_grad_g;
                pixel[c_b_lsb +: B_WIDTH] = w_grad_b;
            end
            default:         pixel = c_black;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fg_pattern_responder.sv
`default_nettype none
// ============================================================================
//  Module      : fg_pattern_responder
//  Description : SRAM-free foreground pixel responder answering in-range
//                requests with a synthesised pattern after LATENCY cycles.
//                Optional border overlay: define FG_PATTERN_BORDER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fg_pattern_responder
    import fg_pattern_pkg::*;
#(
    parameter int PRECISION  = 11,
    parameter int R_WIDTH    = 5,
    parameter int G_WIDTH    = 6,
    parameter int B_WIDTH    = 5,
    parameter int FRAME_W    = 800,
    parameter int FRAME_H    = 600,
    parameter int LATENCY    = 2,
    parameter int BAR_LOG2   = 7,
    parameter int CHECK_LOG2 = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        request_active,
    input  logic signed [PRECISION:0]   request_x,
    input  logic signed [PRECISION:0]   request_y,
    input  logic [1:0]                  ctrl_pattern_mode,
    input  logic [15:0]                 ctrl_solid_colour,
    output logic                        request_ready,
    output logic [15:0]                 request_data
);

    logic [1:0]           r_mode;
    logic [7:0]           r_frame_cnt;
    logic [PRECISION-1:0] w_x;
    logic [PRECISION-1:0] w_y;
    logic                 w_in_range;
    logic                 w_frame_start;
    logic                 w_accept_vld;
    logic [1:0]           w_mode_eff;
    logic [7:0]           w_cnt_eff;
    logic [15:0]          w_pattern;
    logic [15:0]          w_pixel;
    logic                 w_border;

    logic                 r_vld [LATENCY];
    logic [15:0]          r_dat [LATENCY];

    assign w_x = request_x[PRECISION-1:0];
    assign w_y = request_y[PRECISION-1:0];

    assign w_in_range = !request_x[PRECISION] && !request_y[PRECISION] &&
                        (w_x < PRECISION'(FRAME_W)) && (w_y < PRECISION'(FRAME_H));

    assign w_frame_start = request_active && (request_x == '0) && (request_y == '0);
    assign w_accept_vld  = request_active && w_in_range;

    // The frame-start pixel already uses the newly latched mode and count.
    assign w_mode_eff = w_frame_start ? ctrl_pattern_mode  : r_mode;
    assign w_cnt_eff  = w_frame_start ? r_frame_cnt + 8'd1 : r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= c_mode_solid;
            r_frame_cnt <= 8'd0;
        end else if (w_frame_start) begin
            r_mode      <= ctrl_pattern_mode;
            r_frame_cnt <= w_cnt_eff;
        end
    end

    fg_pattern_colour #(
        .PRECISION  (PRECISION),
        .R_WIDTH    (R_WIDTH),
        .G_WIDTH    (G_WIDTH),
        .B_WIDTH    (B_WIDTH),
        .BAR_LOG2   (BAR_LOG2),
        .CHECK_LOG2 (CHECK_LOG2)
    ) u_colour (
        .x            (w_x),
        .y            (w_y),
        .mode         (w_mode_eff),
        .frame_cnt    (w_cnt_eff),
        .solid_colour (ctrl_solid_colour),
        .pixel        (w_pattern)
    );

`ifdef FG_PATTERN_BORDER_EN
    assign w_border = (w_x == '0) || (w_y == '0) ||
                      (w_x == PRECISION'(FRAME_W - 1)) || (w_y == PRECISION'(FRAME_H - 1));
`else
    assign w_border = 1'b0;
`endif

    assign w_pixel = w_border ? c_white : w_pattern;

    // Data only advances with a valid slot, so the output holds its last pixel.
    generate
        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            logic        w_vld_in;
            logic [15:0] w_dat_in;

            if (i == 0) begin : g_head
                assign w_vld_in = w_accept_vld;
                assign w_dat_in = w_pixel;
            end else begin : g_tail
                assign w_vld_in = r_vld[i-1];
                assign w_dat_in = r_dat[i-1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld[i] <= 1'b0;
                    r_dat[i] <= '0;
                end else begin
                    r_vld[i] <= w_vld_in;
                    if (w_vld_in) begin
                        r_dat[i] <= w_dat_in;
                    end
                end
            end
        end
    endgenerate

    assign request_ready = r_vld[LATENCY-1];
    assign request_data  = r_dat[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_fg_pattern_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fg_pattern_responder
//  Description : Self-checking bench for fg_pattern_responder: directed pixel
//                checks plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fg_pattern_responder;

    localparam int PRECISION = 11;
    localparam int XW        = PRECISION + 1;
    localparam int FRAME_W   = 800;
    localparam int FRAME_H   = 600;
    localparam int LATENCY   = 2;
`ifdef FG_PATTERN_BORDER_EN
    localparam bit c_border  = 1'b1;
`else
    localparam bit c_border  = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 request_active = 1'b0;
    logic signed [XW-1:0] request_x = '0;
    logic signed [XW-1:0] request_y = '0;
    logic [1:0]           ctrl_pattern_mode = 2'd0;
    logic [15:0]          ctrl_solid_colour = 16'h0000;
    logic                 request_ready;
    logic [15:0]          request_data;

    always #5 clk = ~clk;

    fg_pattern_responder #(
        .PRECISION (PRECISION),
        .FRAME_W   (FRAME_W),
        .FRAME_H   (FRAME_H),
        .LATENCY   (LATENCY)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .request_active    (request_active),
        .request_x         (request_x),
        .request_y         (request_y),
        .ctrl_pattern_mode (ctrl_pattern_mode),
        .ctrl_solid_colour (ctrl_solid_colour),
        .request_ready     (request_ready),
        .request_data      (request_data)
    );

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  check_en = 1'b0;

    // Reference state: frame bookkeeping and a delay line of (valid, pixel).
    int  m_cnt  = 0;
    int  m_mode = 0;
    bit  h_vld [LATENCY];
    int  h_dat [LATENCY];
    bit  exp_ready = 1'b0;
    int  exp_data  = 0;
    int  mx, my, md;
    bit  mv;

    logic        obs_rdy [int];
    logic [15:0] obs_dat [int];

    function automatic int ref_pixel(int x, int y, int mode, int cnt, int solid);
        int i, c, r, g, b;
        if (c_border && (x == 0 || y == 0 || x == FRAME_W-1 || y == FRAME_H-1))
            return 'hFFFF;
        case (mode)
            0: return solid;
            1: begin
                i = (x / 128) % 8;
                c = 7 - i;
                r = (c & 4) ? 31 : 0;
                g = (c & 2) ? 63 : 0;
                b = (c & 1) ? 31 : 0;
                return r * 2048 + g * 32 + b;
            end
            2: return (((x / 16) + (y / 16)) % 2 == 1) ? 'hFFFF : 0;
            default: begin
                r = ((x / 8) + cnt) % 32;
                g = (y / 8) % 64;
                b = cnt / 8;
                return r * 2048 + g * 32 + b;
            end
        endcase
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_cnt  = 0;
            m_mode = 0;
            for (int k = 0; k < LATENCY; k++) begin
                h_vld[k] = 1'b0;
                h_dat[k] = 0;
            end
            exp_ready = 1'b0;
            exp_data  = 0;
        end else begin
            mx = int'(request_x);
            my = int'(request_y);
            mv = 1'b0;
            md = 0;
            if (request_active) begin
                if (mx == 0 && my == 0) begin
                    m_mode = int'(ctrl_pattern_mode);
                    m_cnt  = (m_cnt + 1) % 256;
                end
                if (mx >= 0 && my >= 0 && mx < FRAME_W && my < FRAME_H) begin
                    mv = 1'b1;
                    md = ref_pixel(mx, my, m_mode, m_cnt, int'(ctrl_solid_colour));
                end
            end
            for (int k = LATENCY-1; k > 0; k--) begin
                h_vld[k] = h_vld[k-1];
                h_dat[k] = h_dat[k-1];
            end
            h_vld[0] = mv;
            h_dat[0] = md;
            exp_ready = h_vld[LATENCY-1];
            if (exp_ready) exp_data = h_dat[LATENCY-1];
        end
    end

    // Single compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        obs_rdy[cyc] = request_ready;
        obs_dat[cyc] = request_data;
        if (check_en) begin
            n_vec++;
            if (request_ready !== exp_ready) begin
                n_err++;
                $display("FAIL model_ready cyc=%0d: got %b, want %b", cyc, request_ready, exp_ready);
            end
            n_vec++;
            if (request_data !== 16'(exp_data)) begin
                n_err++;
                $display("FAIL model_data cyc=%0d: got %h, want %h", cyc, request_data, 16'(exp_data));
            end
        end
    end

    task automatic req(input int x, input int y, output int c);
        @(negedge clk);
        request_active = 1'b1;
        request_x      = XW'(x);
        request_y      = XW'(y);
        c              = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            request_active = 1'b0;
        end
    endtask

    task automatic check_resp(input string name, input int c, input bit er, input int ed);
        int k;
        k = c + LATENCY;
        n_vec++;
        if (!obs_rdy.exists(k)) begin
            n_err++;
            $display("FAIL %s: no response observed at cycle %0d", name, k);
        end else if (obs_rdy[k] !== er || (er && obs_dat[k] !== 16'(ed))) begin
            n_err++;
            $display("FAIL %s: got ready=%b data=%h, want ready=%b data=%h",
                     name, obs_rdy[k], obs_dat[k], er, 16'(ed));
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        request_active = 1'b0;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    int c0, c1, c2, c3;
    int rx, ry, sel;

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: no response, data at zero.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (request_ready !== 1'b0 || request_data !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_idle: got ready=%b data=%h, want ready=0 data=0000",
                         request_ready, request_data);
            end
        end

        // Colour bars with an out-of-range x.
        ctrl_pattern_mode = 2'd1;
        req(0, 0, c0);
        req(128, 0, c1);
        req(896, 0, c2);
        idle(LATENCY + 2);
        check_resp("bars_white", c0, 1'b1, 'hFFFF);
        check_resp("bars_yellow", c1, 1'b1, c_border ? 'hFFFF : 'hFFE0);
        check_resp("bars_x_oor", c2, 1'b0, 0);

        // Range boundaries.
        req(-1, 5, c0);
        req(5, -1, c1);
        req(799, 599, c2);
        req(800, 0, c3);
        idle(LATENCY + 2);
        check_resp("range_xneg", c0, 1'b0, 0);
        check_resp("range_yneg", c1, 1'b0, 0);
        check_resp("range_corner", c2, 1'b1, c_border ? 'hFFFF : 'h001F);
        check_resp("range_xmax", c3, 1'b0, 0);

        // Checker, then a mid-frame mode change that waits for frame start.
        ctrl_pattern_mode = 2'd2;
        req(0, 0, c0);
        req(16, 0, c1);
        req(16, 16, c2);
        idle(LATENCY + 2);
        check_resp("checker_white", c1, 1'b1, 'hFFFF);
        check_resp("checker_black", c2, 1'b1, 'h0000);
        ctrl_pattern_mode = 2'd0;
        ctrl_solid_colour = 16'h1234;
        req(16, 1, c0);
        req(0, 0, c1);
        req(16, 1, c2);
        idle(LATENCY + 2);
        check_resp("mode_held", c0, 1'b1, 'hFFFF);
        check_resp("mode_new_frame", c2, 1'b1, 'h1234);

        // Gradient frame counter from a fresh reset.
        do_reset(2);
        ctrl_pattern_mode = 2'd3;
        req(0, 0, c0);
        req(0, 0, c1);
        req(0, 0, c2);
        req(8, 0, c3);
        idle(LATENCY + 2);
        check_resp("grad_f1", c0, 1'b1, c_border ? 'hFFFF : 'h0800);
        check_resp("grad_f2", c1, 1'b1, c_border ? 'hFFFF : 'h1000);
        check_resp("grad_f3", c2, 1'b1, c_border ? 'hFFFF : 'h1800);
        check_resp("grad_x8", c3, 1'b1, c_border ? 'hFFFF : 'h2000);

        // Reset while a request is in flight discards it.
        req(8, 1, c0);
        @(negedge clk);
        rst = 1'b1;
        request_active = 1'b1;
        request_x = XW'(16);
        request_y = XW'(1);
        @(negedge clk);
        request_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check_resp("reset_discard", c0, 1'b0, 0);
        ctrl_pattern_mode = 2'd3;
        req(0, 0, c0);
        idle(LATENCY + 2);
        check_resp("reset_cnt", c0, 1'b1, c_border ? 'hFFFF : 'h0800);

`ifdef FG_PATTERN_BORDER_EN
        ctrl_pattern_mode = 2'd0;
        ctrl_solid_colour = 16'h001F;
        req(0, 0, c0);
        req(0, 300, c1);
        req(1, 300, c2);
        idle(LATENCY + 2);
        check_resp("border_left", c1, 1'b1, 'hFFFF);
        check_resp("border_inner", c2, 1'b1, 'h001F);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom % 250 == 0);
            request_active = ($urandom % 4 != 0);
            sel = $urandom % 16;
            if (sel == 0) begin
                rx = 0;
                ry = 0;
            end else if (sel == 1) begin
                rx = ($urandom % 2 == 0) ? FRAME_W - 1 : FRAME_W;
                ry = ($urandom % 2 == 0) ? FRAME_H - 1 : -1;
            end else begin
                rx = int'($urandom_range(840, 0)) - 20;
                ry = int'($urandom_range(640, 0)) - 20;
            end
            request_x = XW'(rx);
            request_y = XW'(ry);
            if ($urandom % 40 == 0) ctrl_pattern_mode = 2'($urandom);
            ctrl_solid_colour = 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(LATENCY + 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fg_pattern_responder.md
Name: fg_pattern_responder

Overview:
- Responder side of the pipeline's foreground pixel request interface: request_active, request_x and request_y in; request_ready and request_data out.
- Used in place of sram_wrapper for bring-up and SRAM-free operation.
- Answers each in-range request with a synthesised RGB565 test-pattern pixel after a fixed latency.
- Sits in the clk80 domain, driven by the pipeline's fg_pixel_request_* outputs.

Parameters:
- PRECISION, 11: unsigned coordinate width; request coordinates are PRECISION+1 bits signed.
- R_WIDTH / G_WIDTH / B_WIDTH, 5 / 6 / 5: colour field widths; pixel layout is {R,G,B}, MSB first.
- FRAME_W, 800: visible foreground width in pixels.
- FRAME_H, 600: visible foreground height in pixels.
- LATENCY, 2: cycles from request acceptance to response; legal range 1..8.
- BAR_LOG2, 7: log2 of the colour-bar width in pixels.
- CHECK_LOG2, 4: log2 of the checkerboard square size.

Ports:
- clk  in  1  system clock (clk80)
- rst  in  1  synchronous active-high reset
- request_active  in  1  request valid this cycle
- request_x  in  PRECISION+1  signed x
- request_y  in  PRECISION+1  signed y
- ctrl_pattern_mode  in  2  0 solid, 1 bars, 2 checker, 3 gradient
- ctrl_solid_colour  in  16  colour for mode 0
- request_ready  out  1  response valid; 0 means skip
- request_data  out  16  response pixel

Behaviour:
- Reset:
  - request_ready=0, request_data=16'h0000.
  - Latency pipeline flushed: all valid bits cleared.
  - frame_cnt (8 bit) = 0.
  - Latched mode = 0.
- Reset asserted mid-operation: in-flight requests are discarded and never answered.
- Throughput: one request accepted every cycle; no backpressure.
  - Request accepted at cycle T produces its response at cycle T+LATENCY.
  - Responses are in order.
  - request_ready is 1 for exactly one cycle per in-range request.
  - Cycles with no request give request_ready=0; request_data holds its last value.
- Range check: a request is out of range if x<0, y<0, x>=FRAME_W or y>=FRAME_H.
  - Out-of-range requests occupy their pipeline slot with valid=0.
  - They produce request_ready=0 at T+LATENCY.
- Frame start: an accepted request with x==0 and y==0.
  - At frame start, latched mode <= ctrl_pattern_mode and frame_cnt <= frame_cnt+1 (wraps 255->0).
  - The frame-start request itself is coloured with the newly latched mode and the incremented frame_cnt.
  - Mid-frame changes to ctrl_pattern_mode have no effect until the next frame start.
- ctrl_solid_colour is sampled at acceptance, not latched per frame.
- Colour function (x, y are the non-negative in-range values):
  - mode 0: ctrl_solid_colour.
  - mode 1 (bars): i = x[BAR_LOG2+2:BAR_LOG2], c = 7-i.
    - R = all-ones if c[2] else 0; G = all-ones if c[1] else 0; B = all-ones if c[0] else 0.
    - i=0 gives white (16'hFFFF); i=7 gives black.
  - mode 2 (checker): x[CHECK_LOG2]^y[CHECK_LOG2] ? 16'hFFFF : 16'h0000.
  - mode 3 (gradient), all sums truncated mod 2^width:
    - R = x[7:3] + frame_cnt[4:0].
    - G = y[8:3].
    - B = frame_cnt[7:3].
- The colour is computed in the acceptance cycle; the remaining LATENCY-1 stages are pure delay.

Optional Feature:
- Macro FG_PATTERN_BORDER_EN.
- Defined: any in-range pixel with x==0, y==0, x==FRAME_W-1 or y==FRAME_H-1 returns 16'hFFFF in every mode, overriding the pattern. Latency is unchanged.
- Undefined: no border; the pattern applies to every in-range pixel.

Decomposition:
- Package fg_pattern_pkg:
  - pixel width constants and the RGB565 field positions;
  - the pattern mode encoding constants (SOLID, BARS, CHECKER, GRADIENT);
  - the 8-entry bar colour function.
- Sub-module fg_pattern_colour: combinational; inputs x, y, mode, frame_cnt, solid colour; output 16-bit pixel.
- Top level holds the range check, frame-start latch, frame_cnt and the LATENCY-stage valid/data shift pipeline.

Test Plan:
- Reset then idle 10 cycles -> request_ready=0 and request_data=0 throughout.
- mode=1, requests (0,0),(128,0),(896,0) on consecutive cycles, LATENCY=2:
  - (0,0) and (128,0) give ready=1 at T+2 and T+3 with data 16'hFFFF then 16'hFFE0 (yellow);
  - (896,0) is out of range (FRAME_W=800) and gives ready=0 at T+4.
- Requests (-1,5), (5,-1), (799,599), (800,0) -> ready pattern 0,0,1,0; no gaps or reordering.
- mode=2 latched via a (0,0) request:
  - (16,0) -> 16'hFFFF; (16,16) -> 16'h0000.
  - Switch ctrl_pattern_mode to 0 mid-frame: pixels stay checker until the next (0,0) request, then show ctrl_solid_colour.
- mode=3: issue three (0,0) requests -> frame_cnt 1,2,3; (8,0) in the third frame -> R=4, G=0, B=0, i.e. 16'h2000.
- Assert rst with two requests in flight -> ready stays 0 after reset; frame_cnt=0; a subsequent (0,0) request gives frame_cnt=1.
- With FG_PATTERN_BORDER_EN defined, mode=0 with colour 16'h001F: (0,300) -> 16'hFFFF; (1,300) -> 16'h001F.
